lsu_align_fsm: RTL and testbench
================================

# lsu_align_fsm

Load/store unit between the execute stage and the data cache. It takes the memory-control outputs of the instruction decoder (read/write strobes, load-type and store-type codes), forms word-aligned cache requests with byte enables, and stalls the core until the cache completes the request. On loads it returns sign- or zero-extended data. It also flags misaligned accesses and cache timeouts.

## Interface
Parameters:
- TIMEOUT, 255: maximum number of cycles in REQ waiting for `dc_ready_i`. Range 1..1023.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous reset, active-low
- mem_read_i  in  1  load request from the decoder
- mem_write_i  in  1  store request; has priority if asserted together with `mem_read_i`
- load_i  in  3  000 LW, 001 LH, 010 LB, 011 LHU, 100 LBU; 101–111 treated as LW
- store_i  in  2  00 SW, 01 SH, 10 SB; 11 treated as SW
- addr_i  in  32  byte address from the ALU
- wdata_i  in  32  store data (rs2)
- dc_req_o  out  1  cache request, held high until `dc_ready_i`
- dc_we_o  out  1  1 = write
- dc_addr_o  out  32  `{addr[31:2],2'b00}`
- dc_wdata_o  out  32  lane-replicated store data
- dc_be_o  out  4  byte enables (all 0 on reads)
- dc_ready_i  in  1  cache completion; read data is valid in the same cycle
- dc_rdata_i  in  32  cache read word
- stall_o  out  1  freeze the pipeline
- rdata_o  out  32  extended load result
- rdata_valid_o  out  1  one-cycle pulse when `rdata_o` is new
- misalign_o  out  1  misaligned-access flag
- err_o  out  1  one-cycle timeout pulse

## Operation
The unit is a three-state machine: IDLE, REQ, DONE.

- **IDLE**
  - An access is `mem_read_i | mem_write_i`.
  - If the access is aligned: latch the type, address, data, we and be, assert `stall_o`, and go to REQ.
  - If the access is misaligned (word type with `addr[1:0]≠0`, or half type with `addr[0]≠0`):
    - `misalign_o=1` combinationally;
    - `stall_o=0`, and no request is issued;
    - stay in IDLE.
- **REQ**
  - `dc_req_o=1` and `stall_o=1`. Request fields stay stable for the whole state.
  - Cycle counter: cleared on entry, incremented each cycle.
  - On `dc_ready_i`:
    - for a read, register the extended data into `rdata_o`;
    - go to DONE.
  - If the counter reaches TIMEOUT−1 with no ready:
    - drop the request;
    - `rdata_o=0`;
    - go to DONE with the error flagged.
- **DONE**
  - `stall_o=0`, so the instruction advances.
  - `rdata_valid_o=1` for reads, including timed-out reads.
  - `err_o=1` if the access timed out.
  - Inputs are ignored, because they still belong to the completing instruction.
  - Next state is always IDLE.

Store formatting:
- **SB:** `be=1<<addr[1:0]`, `wdata={4{wdata_i[7:0]}}`
- **SH:** `be=addr[1]?1100:0011`, `wdata={2{wdata_i[15:0]}}`
- **SW:** `be=1111`, `wdata=wdata_i`

Load extraction:
- Byte at lane `addr[1:0]`, half at `addr[1]`.
- LB and LH sign-extend from bit 7 or 15. LBU and LHU zero-extend. LW passes the word through.
- `rdata_o` holds its value until the next completed read.

## Timing
- **Reset:** asynchronous, forces IDLE immediately. Outputs during reset:
  - `dc_req_o`, `dc_we_o`, `dc_be_o` = 0
  - `dc_addr_o`, `dc_wdata_o`, `rdata_o` = 0
  - `stall_o`, `rdata_valid_o`, `err_o` = 0
  - counter = 0
- **Reset mid-REQ:** the request drops in the same cycle. No DONE state and no pulse follow.
- **Cycle sequence (ready on first REQ cycle):**
  - cycle N: access seen in IDLE (stall).
  - cycle N+1: REQ.
  - cycle N+2: DONE (no stall).
  - Minimum stall is 2 cycles. Each cycle without ready adds one stall cycle.
- **Timeout:** DONE occurs at cycle N+1+TIMEOUT.
- **Combinational vs registered outputs:**
  - `misalign_o` and the IDLE-state `stall_o` are combinational.
  - All `dc_*` outputs are registered (driven from state and latched fields).
- **`dc_ready_i` outside REQ** is ignored.

## Test plan
- **LB:**
  - Stimulus: addr 0x1003, cache word 0x80FF_1234, `load_i=010`.
  - Required: `dc_addr_o=0x1000`, `be=0000`, `rdata_o=0xFFFF_FF80`, `rdata_valid_o` at N+2, stall high for exactly 2 cycles.
- **SH:**
  - Stimulus: addr 0x2002, `wdata_i=0xAAAA_BEEF`, ready delayed 3 cycles.
  - Required: `dc_we_o=1`, `be=1100`, `dc_wdata_o=0xBEEF_BEEF`, request stable for 4 REQ cycles, stall released at DONE, no `rdata_valid_o`.
- **LHU / LBU:**
  - Stimulus: LHU at addr 0x0002 with word 0x9ABC_0000; LBU at addr 0x0001 with word 0x0000_F000.
  - Required: `rdata_o=0x0000_9ABC`, then `0x0000_00F0`.
- **Misaligned:**
  - Stimulus: LW at addr 0x0006.
  - Required: `misalign_o=1` in that cycle, `stall_o=0`, `dc_req_o` stays 0, state stays IDLE.
- **Timeout:**
  - Stimulus: TIMEOUT=4, `dc_ready_i` held low on a load.
  - Required: 4 REQ cycles, then DONE with `err_o=1`, `rdata_o=0`, `rdata_valid_o=1`.
- **Reset mid-REQ:**
  - Stimulus: `rst_n` low in the second REQ cycle.
  - Required: all outputs 0 at once. After release, IDLE accepts a new SW at 0x10 with `be=1111`.

Source files
------------

// File: rtl/lsu_align_fsm.sv
// -----------------------------------------------------------------------------
// lsu_align_fsm
// Load/store unit sitting between execute and the data cache. Turns decoder
// memory-control strobes into a word-aligned cache request with byte enables,
// holds the pipeline stalled until the cache answers (or times out), and
// returns sign/zero-extended load data.
//
// State table
//   state  | meaning
//   IDLE   | waiting for an access; misaligned accesses are flagged here
//   REQ    | cache request held high, waiting for dc_ready_i or timeout
//   DONE   | one-cycle completion: stall released, valid/err pulses out
//
// Ports
//   clk, rst_n           clock, async active-low reset
//   mem_read_i/_write_i  access strobes from the decoder (write has priority)
//   load_i, store_i      load / store type codes
//   addr_i, wdata_i      byte address and store data
//   dc_*_o               registered cache request fields
//   dc_ready_i/rdata_i   cache completion and read word
//   stall_o              pipeline freeze
//   rdata_o/_valid_o     extended load result and its one-cycle valid pulse
//   misalign_o           combinational misaligned-access flag (IDLE only)
//   err_o                one-cycle timeout pulse
// -----------------------------------------------------------------------------
module lsu_align_fsm #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [2:0]  load_i,
   input  logic [1:0]  store_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        dc_req_o,
   output logic        dc_we_o,
   output logic [31:0] dc_addr_o,
   output logic [31:0] dc_wdata_o,
   output logic [3:0]  dc_be_o,
   input  logic        dc_ready_i,
   input  logic [31:0] dc_rdata_i,
   output logic        stall_o,
   output logic [31:0] rdata_o,
   output logic        rdata_valid_o,
   output logic        misalign_o,
   output logic        err_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int unsigned CW = 10;
   localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_dc_req;
   logic          r_dc_we;
   logic [31:0]   r_dc_addr;
   logic [31:0]   r_dc_wdata;
   logic [3:0]    r_dc_be;
   logic [2:0]    r_ld_type;
   logic [1:0]    r_lane;
   logic [31:0]   r_rdata;
   logic          r_rdata_valid;
   logic          r_err;

   logic          w_access;
   logic          w_word;
   logic          w_half;
   logic          w_misalign;
   logic          w_accept;
   logic [3:0]    w_be;
   logic [31:0]   w_wdata;
   logic [7:0]    w_byte;
   logic [15:0]   w_halfw;
   logic [31:0]   w_ext;

   // Access decode and store formatting (write strobe selects the store codes)
   always_comb begin
      w_access = mem_read_i | mem_write_i;
      w_word   = 1'b0;
      w_half   = 1'b0;
      w_be     = 4'b1111;
      w_wdata  = wdata_i;
      if (mem_write_i) begin
         w_word = (store_i == 2'b00) || (store_i == 2'b11);
         w_half = (store_i == 2'b01);
      end else begin
         w_word = (load_i == 3'b000) || (load_i >= 3'b101);
         w_half = (load_i == 3'b001) || (load_i == 3'b011);
      end
      w_misalign = (w_word && (addr_i[1:0] != 2'b00)) || (w_half && addr_i[0]);
      w_accept   = (r_state == S_IDLE) && w_access && !w_misalign;
      case (store_i)
         2'b01: begin
            w_be    = addr_i[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{wdata_i[15:0]}};
         end
         2'b10: begin
            w_be    = 4'b0001 << addr_i[1:0];
            w_wdata = {4{wdata_i[7:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = wdata_i;
         end
      endcase
   end

   // Load extraction from the cache word using the latched lane and type
   always_comb begin
      case (r_lane)
         2'd0:    w_byte = dc_rdata_i[7:0];
         2'd1:    w_byte = dc_rdata_i[15:8];
         2'd2:    w_byte = dc_rdata_i[23:16];
         default: w_byte = dc_rdata_i[31:24];
      endcase
      w_halfw = r_lane[1] ? dc_rdata_i[31:16] : dc_rdata_i[15:0];
      case (r_ld_type)
         3'b001:  w_ext = {{16{w_halfw[15]}}, w_halfw};
         3'b010:  w_ext = {{24{w_byte[7]}}, w_byte};
         3'b011:  w_ext = {16'h0000, w_halfw};
         3'b100:  w_ext = {24'h000000, w_byte};
         default: w_ext = dc_rdata_i;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_dc_req      <= 1'b0;
         r_dc_we       <= 1'b0;
         r_dc_addr     <= '0;
         r_dc_wdata    <= '0;
         r_dc_be       <= '0;
         r_ld_type     <= '0;
         r_lane        <= '0;
         r_rdata       <= '0;
         r_rdata_valid <= 1'b0;
         r_err         <= 1'b0;
      end else begin
         r_rdata_valid <= 1'b0;
         r_err         <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state    <= S_REQ;
                  r_cnt      <= '0;
                  r_dc_req   <= 1'b1;
                  r_dc_we    <= mem_write_i;
                  r_dc_addr  <= {addr_i[31:2], 2'b00};
                  r_dc_wdata <= w_wdata;
                  r_dc_be    <= mem_write_i ? w_be : 4'b0000;
                  r_ld_type  <= load_i;
                  r_lane     <= addr_i[1:0];
               end
            end
            S_REQ: begin
               if (dc_ready_i) begin
                  r_state  <= S_DONE;
                  r_dc_req <= 1'b0;
                  r_dc_we  <= 1'b0;
                  r_dc_be  <= 4'b0000;
                  if (!r_dc_we) begin
                     r_rdata       <= w_ext;
                     r_rdata_valid <= 1'b1;
                  end
               end else if (r_cnt == C_LAST) begin
                  // Timed out: a read still completes, with zero data
                  r_state  <= S_DONE;
                  r_dc_req <= 1'b0;
                  r_dc_we  <= 1'b0;
                  r_dc_be  <= 4'b0000;
                  r_err    <= 1'b1;
                  if (!r_dc_we) begin
                     r_rdata       <= '0;
                     r_rdata_valid <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign dc_req_o      = r_dc_req;
   assign dc_we_o       = r_dc_we;
   assign dc_addr_o     = r_dc_addr;
   assign dc_wdata_o    = r_dc_wdata;
   assign dc_be_o       = r_dc_be;
   assign rdata_o       = r_rdata;
   assign rdata_valid_o = r_rdata_valid;
   assign err_o         = r_err;
   // IDLE-path terms are gated by rst_n so reset forces them low immediately
   assign misalign_o    = rst_n & (r_state == S_IDLE) & w_access & w_misalign;
   assign stall_o       = (r_state == S_REQ) | (rst_n & w_accept);

endmodule

// File: tb/tb_lsu_align_fsm.sv
module tb_lsu_align_fsm;

   localparam int TO = 4;

   logic        clk;
   logic        rst_n;
   logic        mem_read_i;
   logic        mem_write_i;
   logic [2:0]  load_i;
   logic [1:0]  store_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        dc_req_o;
   logic        dc_we_o;
   logic [31:0] dc_addr_o;
   logic [31:0] dc_wdata_o;
   logic [3:0]  dc_be_o;
   logic        dc_ready_i;
   logic [31:0] dc_rdata_i;
   logic        stall_o;
   logic [31:0] rdata_o;
   logic        rdata_valid_o;
   logic        misalign_o;
   logic        err_o;

   int errors = 0;
   int checks = 0;

   // observations captured by the access driver
   logic        o_first_stall, o_first_mis, o_first_req;
   int          o_req_cycles;
   logic        o_stable, o_bound_hit;
   logic        o_we;
   logic [31:0] o_addr, o_wdata;
   logic [3:0]  o_be;
   logic        o_done_stall, o_done_valid, o_done_err;
   logic [31:0] o_done_rdata;
   logic        o_after_valid, o_after_err, o_after_req, o_after_stall;
   logic [31:0] o_after_rdata;

   logic [31:0] exp_rdata;   // model of the value rdata_o must hold

   lsu_align_fsm #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
      .load_i(load_i), .store_i(store_i),
      .addr_i(addr_i), .wdata_i(wdata_i),
      .dc_req_o(dc_req_o), .dc_we_o(dc_we_o), .dc_addr_o(dc_addr_o),
      .dc_wdata_o(dc_wdata_o), .dc_be_o(dc_be_o),
      .dc_ready_i(dc_ready_i), .dc_rdata_i(dc_rdata_i),
      .stall_o(stall_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
      .misalign_o(misalign_o), .err_o(err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic int access_size(input bit we, input logic [2:0] lt, input logic [1:0] st);
      if (we) return (st == 2'd2) ? 1 : (st == 2'd1) ? 2 : 4;
      if (lt == 3'd2 || lt == 3'd4) return 1;
      if (lt == 3'd1 || lt == 3'd3) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] lt, input logic [31:0] a, input logic [31:0] w);
      int unsigned lane = a % 4;
      int unsigned b = (w >> (8 * lane)) & 255;
      int unsigned h = (w >> (16 * (lane / 2))) & 65535;
      case (lt)
         3'd1: return (h >= 32768) ? 32'(h + 32'hFFFF_0000) : 32'(h);
         3'd2: return (b >= 128) ? 32'(b + 32'hFFFF_FF00) : 32'(b);
         3'd3: return 32'(h);
         3'd4: return 32'(b);
         default: return w;
      endcase
   endfunction

   function automatic logic [3:0] model_be(input logic [1:0] st, input logic [31:0] a);
      int unsigned lane = a % 4;
      if (st == 2'd2) return 4'(1 << lane);
      if (st == 2'd1) return (lane >= 2) ? 4'b1100 : 4'b0011;
      return 4'b1111;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [1:0] st, input logic [31:0] wd);
      if (st == 2'd2) return (wd & 32'hFF) * 32'h0101_0101;
      if (st == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
      return wd;
   endfunction

   // ---------------- access driver (stimulus + capture only) ----------------
   task automatic drive_access(input bit we, input logic [2:0] lt, input logic [1:0] st,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] rw, input int dly);
      @(negedge clk);
      mem_write_i = we;
      mem_read_i  = we ? 1'($urandom_range(0, 1)) : 1'b1;
      load_i  = lt;
      store_i = st;
      addr_i  = a;
      wdata_i = wd;
      dc_ready_i = 1'($urandom_range(0, 1));
      #1;
      o_first_stall = stall_o;
      o_first_mis   = misalign_o;
      o_first_req   = dc_req_o;
      @(posedge clk);
      #1;
      mem_read_i  = 1'b0;
      mem_write_i = 1'b0;
      addr_i  = $urandom;
      wdata_i = $urandom;
      load_i  = 3'($urandom);
      store_i = 2'($urandom);
      dc_ready_i = 1'b0;
      o_req_cycles = 0;
      o_stable = 1'b1;
      o_bound_hit = 1'b0;
      forever begin
         @(negedge clk);
         if (!dc_req_o) break;
         if (o_req_cycles == 0) begin
            o_we = dc_we_o; o_addr = dc_addr_o; o_be = dc_be_o; o_wdata = dc_wdata_o;
         end else if ({dc_we_o, dc_addr_o, dc_be_o, dc_wdata_o} !== {o_we, o_addr, o_be, o_wdata}) begin
            o_stable = 1'b0;
         end
         if (stall_o !== 1'b1) o_stable = 1'b0;
         o_req_cycles++;
         if (o_req_cycles - 1 == dly) begin
            dc_ready_i = 1'b1; dc_rdata_i = rw;
         end else begin
            dc_ready_i = 1'b0; dc_rdata_i = $urandom;
         end
         if (o_req_cycles > 2000) begin
            o_bound_hit = 1'b1;
            break;
         end
      end
      o_done_stall = stall_o;
      o_done_valid = rdata_valid_o;
      o_done_err   = err_o;
      o_done_rdata = rdata_o;
      // ready outside REQ must be ignored
      dc_ready_i = 1'($urandom_range(0, 1));
      dc_rdata_i = $urandom;
      @(negedge clk);
      o_after_valid = rdata_valid_o;
      o_after_err   = err_o;
      o_after_req   = dc_req_o;
      o_after_stall = stall_o;
      o_after_rdata = rdata_o;
      dc_ready_i = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      mem_read_i = 1'b1; mem_write_i = 1'b0; load_i = 3'd0; store_i = 2'd0;
      addr_i = 32'h0000_0100; wdata_i = 32'hDEAD_BEEF;
      dc_ready_i = 1'b1; dc_rdata_i = 32'h1234_5678;
      #23;
      checks++;
      if ({dc_req_o, dc_we_o, dc_be_o, dc_addr_o, dc_wdata_o, rdata_o, rdata_valid_o, err_o} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: req=%b we=%b be=%b addr=%h wdata=%h rdata=%h valid=%b err=%b want all 0",
                  dc_req_o, dc_we_o, dc_be_o, dc_addr_o, dc_wdata_o, rdata_o, rdata_valid_o, err_o);
      end
      checks++;
      if ({stall_o, misalign_o} !== 2'b00) begin
         errors++;
         $display("FAIL reset_stall: stall=%b misalign=%b want 0 0", stall_o, misalign_o);
      end
      mem_read_i = 1'b0; dc_ready_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_rdata = 32'h0;
   endtask

   task automatic test_lb();
      drive_access(1'b0, 3'b010, 2'b00, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0);
      checks++;
      if ({o_first_stall, o_first_mis, o_first_req} !== 3'b100) begin
         errors++; $display("FAIL lb_cycleN: stall/mis/req=%b want 100", {o_first_stall, o_first_mis, o_first_req});
      end
      checks++;
      if ({o_we, o_be, o_addr} !== {1'b0, 4'b0000, 32'h0000_1000}) begin
         errors++; $display("FAIL lb_req_fields: we=%b be=%b addr=%h want 0 0000 00001000", o_we, o_be, o_addr);
      end
      checks++;
      if (o_req_cycles != 1 || o_stable !== 1'b1) begin
         errors++; $display("FAIL lb_req_cycles: got %0d stable=%b want 1 stable=1", o_req_cycles, o_stable);
      end
      checks++;
      if ({o_done_stall, o_done_valid, o_done_err} !== 3'b010 || o_done_rdata !== 32'hFFFF_FF80) begin
         errors++; $display("FAIL lb_done: stall/valid/err=%b rdata=%h want 010 ffffff80",
                            {o_done_stall, o_done_valid, o_done_err}, o_done_rdata);
      end
      exp_rdata = 32'hFFFF_FF80;
      checks++;
      if (o_after_valid !== 1'b0 || o_after_rdata !== exp_rdata) begin
         errors++; $display("FAIL lb_hold: valid=%b rdata=%h want 0 %h", o_after_valid, o_after_rdata, exp_rdata);
      end
   endtask

   task automatic test_sh();
      drive_access(1'b1, 3'b000, 2'b01, 32'h0000_2002, 32'hAAAA_BEEF, 32'h0, 3);
      checks++;
      if ({o_we, o_be, o_wdata, o_addr} !== {1'b1, 4'b1100, 32'hBEEF_BEEF, 32'h0000_2000}) begin
         errors++; $display("FAIL sh_fields: we=%b be=%b wdata=%h addr=%h want 1 1100 beefbeef 00002000",
                            o_we, o_be, o_wdata, o_addr);
      end
      checks++;
      if (o_req_cycles != 4 || o_stable !== 1'b1) begin
         errors++; $display("FAIL sh_req_cycles: got %0d stable=%b want 4 stable=1", o_req_cycles, o_stable);
      end
      checks++;
      if ({o_done_stall, o_done_valid, o_done_err} !== 3'b000 || o_done_rdata !== exp_rdata) begin
         errors++; $display("FAIL sh_done: stall/valid/err=%b rdata=%h want 000 %h",
                            {o_done_stall, o_done_valid, o_done_err}, o_done_rdata, exp_rdata);
      end
   endtask

   task automatic test_lhu_lbu();
      drive_access(1'b0, 3'b011, 2'b00, 32'h0000_0002, 32'h0, 32'h9ABC_0000, 1);
      checks++;
      if (o_done_valid !== 1'b1 || o_done_rdata !== 32'h0000_9ABC) begin
         errors++; $display("FAIL lhu_rdata: valid=%b rdata=%h want 1 00009abc", o_done_valid, o_done_rdata);
      end
      drive_access(1'b0, 3'b100, 2'b00, 32'h0000_0001, 32'h0, 32'h0000_F000, 2);
      checks++;
      if (o_done_valid !== 1'b1 || o_done_rdata !== 32'h0000_00F0) begin
         errors++; $display("FAIL lbu_rdata: valid=%b rdata=%h want 1 000000f0", o_done_valid, o_done_rdata);
      end
      exp_rdata = 32'h0000_00F0;
   endtask

   task automatic test_misaligned();
      // {we, rd, load, store, addr}: LW@6, LH@5, LHU@3, SW@2 (write wins over LB), SH@1
      logic [38:0] tbl [5];
      tbl[0] = {1'b0, 1'b1, 3'b000, 2'b00, 32'h0000_0006};
      tbl[1] = {1'b0, 1'b1, 3'b001, 2'b00, 32'h0000_0005};
      tbl[2] = {1'b0, 1'b1, 3'b011, 2'b00, 32'h0000_0003};
      tbl[3] = {1'b1, 1'b1, 3'b010, 2'b00, 32'h0000_0002};
      tbl[4] = {1'b1, 1'b0, 3'b000, 2'b01, 32'h0000_0001};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         {mem_write_i, mem_read_i, load_i, store_i, addr_i} = tbl[i];
         #1;
         checks++;
         if ({misalign_o, stall_o, dc_req_o} !== 3'b100) begin
            errors++; $display("FAIL misalign_%0d: mis/stall/req=%b want 100", i, {misalign_o, stall_o, dc_req_o});
         end
         @(negedge clk);
         checks++;
         if ({misalign_o, stall_o, dc_req_o} !== 3'b100) begin
            errors++; $display("FAIL misalign_stay_%0d: mis/stall/req=%b want 100", i, {misalign_o, stall_o, dc_req_o});
         end
         mem_read_i = 1'b0; mem_write_i = 1'b0;
      end
   endtask

   task automatic test_timeout();
      drive_access(1'b0, 3'b000, 2'b00, 32'h0000_0040, 32'h0, 32'h0, 100);
      checks++;
      if (o_req_cycles != TO || o_bound_hit !== 1'b0) begin
         errors++; $display("FAIL timeout_cycles: got %0d want %0d", o_req_cycles, TO);
      end
      checks++;
      if ({o_done_stall, o_done_valid, o_done_err} !== 3'b011 || o_done_rdata !== 32'h0) begin
         errors++; $display("FAIL timeout_done: stall/valid/err=%b rdata=%h want 011 00000000",
                            {o_done_stall, o_done_valid, o_done_err}, o_done_rdata);
      end
      checks++;
      if ({o_after_err, o_after_valid, o_after_req} !== 3'b000) begin
         errors++; $display("FAIL timeout_pulse: err/valid/req after=%b want 000", {o_after_err, o_after_valid, o_after_req});
      end
      exp_rdata = 32'h0;
   endtask

   task automatic test_reset_mid_req();
      logic [31:0] wd;
      @(negedge clk);
      mem_read_i = 1'b1; load_i = 3'b000; addr_i = 32'h0000_0080;
      @(posedge clk);
      #1;
      mem_read_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (dc_req_o !== 1'b1) begin
         errors++; $display("FAIL rstreq_pre: req=%b want 1", dc_req_o);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({dc_req_o, dc_we_o, dc_be_o, dc_addr_o, dc_wdata_o, stall_o, rdata_o, rdata_valid_o, misalign_o, err_o} !== '0) begin
         errors++; $display("FAIL rstreq_outputs: req=%b stall=%b addr=%h rdata=%h valid=%b err=%b want all 0",
                            dc_req_o, stall_o, dc_addr_o, rdata_o, rdata_valid_o, err_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      exp_rdata = 32'h0;
      @(negedge clk);
      checks++;
      if ({rdata_valid_o, err_o, stall_o, dc_req_o} !== 4'b0000) begin
         errors++; $display("FAIL rstreq_no_done: valid/err/stall/req=%b want 0000",
                            {rdata_valid_o, err_o, stall_o, dc_req_o});
      end
      wd = $urandom;
      drive_access(1'b1, 3'b000, 2'b00, 32'h0000_0010, wd, 32'h0, 0);
      checks++;
      if ({o_first_stall, o_we, o_be, o_addr, o_wdata} !== {1'b1, 1'b1, 4'b1111, 32'h0000_0010, wd}) begin
         errors++; $display("FAIL rstreq_sw: stall=%b we=%b be=%b addr=%h wdata=%h want 1 1 1111 00000010 %h",
                            o_first_stall, o_we, o_be, o_addr, o_wdata, wd);
      end
   endtask

   task automatic test_random(input int n);
      bit we; logic [2:0] lt; logic [1:0] st; logic [31:0] a, wd, rw;
      int dly, sz, exp_cycles; bit tmo;
      for (int i = 0; i < n; i++) begin
         we = 1'($urandom_range(0, 1));
         lt = 3'($urandom_range(0, 7));
         st = 2'($urandom_range(0, 3));
         sz = access_size(we, lt, st);
         a  = $urandom;
         a  = a - (a % sz);
         wd = $urandom; rw = $urandom;
         dly = $urandom_range(0, TO + 1);
         tmo = (dly >= TO);
         exp_cycles = tmo ? TO : dly + 1;
         drive_access(we, lt, st, a, wd, rw, dly);
         checks++;
         if ({o_first_stall, o_first_mis, o_first_req} !== 3'b100) begin
            errors++; $display("FAIL rnd%0d_cycleN: stall/mis/req=%b want 100", i, {o_first_stall, o_first_mis, o_first_req});
         end
         checks++;
         if (o_req_cycles != exp_cycles || o_stable !== 1'b1) begin
            errors++; $display("FAIL rnd%0d_cycles: got %0d stable=%b want %0d", i, o_req_cycles, o_stable, exp_cycles);
         end
         checks++;
         if (o_we !== we || o_addr !== (a & 32'hFFFF_FFFC) || o_be !== (we ? model_be(st, a) : 4'b0000)) begin
            errors++; $display("FAIL rnd%0d_fields: we=%b addr=%h be=%b want %b %h %b", i, o_we, o_addr, o_be,
                               we, a & 32'hFFFF_FFFC, we ? model_be(st, a) : 4'b0000);
         end
         if (we) begin
            checks++;
            if (o_wdata !== model_wdata(st, wd)) begin
               errors++; $display("FAIL rnd%0d_wdata: got %h want %h", i, o_wdata, model_wdata(st, wd));
            end
         end else begin
            exp_rdata = tmo ? 32'h0 : model_load(lt, a, rw);
         end
         checks++;
         if ({o_done_stall, o_done_valid, o_done_err} !== {1'b0, !we, tmo} || o_done_rdata !== exp_rdata) begin
            errors++; $display("FAIL rnd%0d_done: stall/valid/err=%b rdata=%h want %b %h", i,
                               {o_done_stall, o_done_valid, o_done_err}, o_done_rdata, {1'b0, !we, tmo}, exp_rdata);
         end
         checks++;
         if ({o_after_valid, o_after_err, o_after_req, o_after_stall} !== 4'b0000 || o_after_rdata !== exp_rdata) begin
            errors++; $display("FAIL rnd%0d_after: valid/err/req/stall=%b rdata=%h want 0000 %h", i,
                               {o_after_valid, o_after_err, o_after_req, o_after_stall}, o_after_rdata, exp_rdata);
         end
      end
   endtask

   initial begin
      test_reset();
      test_lb();
      test_sh();
      test_lhu_lbu();
      test_misaligned();
      test_timeout();
      test_reset_mid_req();
      test_random(60);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
